// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter for 8 requesters with a registered one-hot grant.
// The grant feeds an 8-to-3 encoder, so gnt is only ever one-hot or zero.
// gnt_valid and gnt_idx are registered in the same update as gnt.
// A grant is held for at most MAX_HOLD cycles while others are waiting.
module rr_onehot_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         gnt_valid,
    output logic [2:0]   gnt_idx
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t     state, nxt_state;
    logic [2:0] ptr, nxt_ptr;
    logic [3:0] hold_cnt, nxt_hold;
    logic       nxt_vld;
    logic [2:0] nxt_idx;

    // Winner search: scan upward from p modulo 8. Iterating from the far end
    // lets the closest set bit overwrite the result last.
    function automatic logic [3:0] pick(input logic [N-1:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = p + 3'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    logic [2:0]   g;
    logic [2:0]   ptr_inc;
    logic [N-1:0] req_masked;
    logic [3:0]   win_ptr;
    logic [3:0]   win_rot;
    logic [3:0]   win_mask;

    assign g          = gnt_idx;
    assign ptr_inc    = g + 3'd1;
    assign req_masked = req & ~(N'(1) << g);
    assign win_ptr    = pick(req, ptr);
    assign win_rot    = pick(req, ptr_inc);
    assign win_mask   = pick(req_masked, ptr_inc);

    // Next-state decision; GRANT cases are evaluated in priority order.
    always_comb begin
        nxt_state = state;
        nxt_ptr   = ptr;
        nxt_hold  = hold_cnt;
        nxt_vld   = gnt_valid;
        nxt_idx   = gnt_idx;
        case (state)
            IDLE: begin
                if (en && win_ptr[3]) begin
                    nxt_state = GRANT;
                    nxt_vld   = 1'b1;
                    nxt_idx   = win_ptr[2:0];
                    nxt_hold  = 4'd1;
                end else begin
                    nxt_vld   = 1'b0;
                    nxt_idx   = 3'd0;
                end
            end
            GRANT: begin
                if (!en) begin
                    nxt_state = IDLE;
                    nxt_ptr   = ptr_inc;
                    nxt_hold  = 4'd0;
                    nxt_vld   = 1'b0;
                    nxt_idx   = 3'd0;
                end else if (!req[g]) begin
                    // Release: rotate and re-arbitrate in the same edge so a
                    // waiting requester is granted without a bubble cycle.
                    nxt_ptr = ptr_inc;
                    if (win_rot[3]) begin
                        nxt_idx  = win_rot[2:0];
                        nxt_hold = 4'd1;
                    end else begin
                        nxt_state = IDLE;
                        nxt_hold  = 4'd0;
                        nxt_vld   = 1'b0;
                        nxt_idx   = 3'd0;
                    end
                end else if (hold_cnt == HOLD_MAX && win_mask[3]) begin
                    // Tenure expired with others waiting: force rotation.
                    nxt_ptr  = ptr_inc;
                    nxt_idx  = win_mask[2:0];
                    nxt_hold = 4'd1;
                end else if (hold_cnt != HOLD_MAX) begin
                    nxt_hold = hold_cnt + 4'd1;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_vld   = 1'b0;
                nxt_idx   = 3'd0;
                nxt_hold  = 4'd0;
            end
        endcase
    end

    // State and registered outputs; gnt, gnt_valid and gnt_idx move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            hold_cnt  <= 4'd0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= 3'd0;
        end else begin
            state     <= nxt_state;
            ptr       <= nxt_ptr;
            hold_cnt  <= nxt_hold;
            gnt       <= nxt_vld ? (N'(1) << nxt_idx) : '0;
            gnt_valid <= nxt_vld;
            gnt_idx   <= nxt_idx;
        end
    end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed, table-driven bench for rr_onehot_arbiter (MAX_HOLD=4).
module tb_rr_onehot_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_idx;

    int checks   = 0;
    int failures = 0;

    rr_onehot_arbiter #(.N(8), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [7:0] req;
        logic [7:0] exp_gnt;
        logic       exp_vld;
        logic [2:0] exp_idx;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic [7:0] q,
                       input logic [7:0] eg, input logic ev, input logic [2:0] ei);
        vec_t v;
        v.rst_n = r; v.en = e; v.req = q;
        v.exp_gnt = eg; v.exp_vld = ev; v.exp_idx = ei;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] eg,
                         input logic ev, input logic [2:0] ei);
        checks++;
        if (gnt !== eg || gnt_valid !== ev || gnt_idx !== ei) begin
            failures++;
            $display("FAIL %s: got gnt=%b vld=%b idx=%0d, want gnt=%b vld=%b idx=%0d",
                     name, gnt, gnt_valid, gnt_idx, eg, ev, ei);
        end
        checks++;
        if ($countones(gnt) > 1) begin
            failures++;
            $display("FAIL %s_onehot: got gnt=%b, want at most one bit set", name, gnt);
        end
    endtask

    initial begin
        // Reset exit: ptr=0 so bit 0 wins, then a lone request on bit 4.
        add(1, 1, 8'hFF, 8'h01, 1, 0);
        add(1, 1, 8'h10, 8'h10, 1, 4);
        add(1, 1, 8'h00, 8'h00, 0, 0);
        // Reset back to ptr=0 for the rotation sequence.
        add(0, 1, 8'h00, 8'h00, 0, 0);
        add(1, 1, 8'h00, 8'h00, 0, 0);
        // Rotation: bit2 x4, bit5 x4, bit2 again.
        add(1, 1, 8'h24, 8'h04, 1, 2);
        add(1, 1, 8'h24, 8'h04, 1, 2);
        add(1, 1, 8'h24, 8'h04, 1, 2);
        add(1, 1, 8'h24, 8'h04, 1, 2);
        add(1, 1, 8'h24, 8'h20, 1, 5);
        add(1, 1, 8'h24, 8'h20, 1, 5);
        add(1, 1, 8'h24, 8'h20, 1, 5);
        add(1, 1, 8'h24, 8'h20, 1, 5);
        add(1, 1, 8'h24, 8'h04, 1, 2);
        // Sole requester: hold count saturates, then a rival forces rotation.
        add(1, 1, 8'h04, 8'h04, 1, 2);
        add(1, 1, 8'h04, 8'h04, 1, 2);
        add(1, 1, 8'h04, 8'h04, 1, 2);
        add(1, 1, 8'h04, 8'h04, 1, 2);
        add(1, 1, 8'h24, 8'h20, 1, 5);
        // Release hand-offs, wrap 7 -> 0 with no zero cycle.
        add(1, 1, 8'h40, 8'h40, 1, 6);
        add(1, 1, 8'h81, 8'h80, 1, 7);
        add(1, 1, 8'h01, 8'h01, 1, 0);
        // Enable drop on bit 6, then ptr=7 wraps to bit 1.
        add(1, 1, 8'h40, 8'h40, 1, 6);
        add(1, 0, 8'h40, 8'h00, 0, 0);
        add(1, 1, 8'h42, 8'h02, 1, 1);
        // en low blocks new grants from IDLE.
        add(1, 0, 8'h42, 8'h00, 0, 0);
        add(1, 0, 8'hFF, 8'h00, 0, 0);
        add(1, 1, 8'hFF, 8'h04, 1, 2);
        add(1, 1, 8'h20, 8'h20, 1, 5);

        // Reset asserted with everything requesting: outputs clear asynchronously.
        rst_n = 1'b0; en = 1'b1; req = 8'hFF;
        #3;
        check("reset_async", 8'h00, 0, 0);
        @(posedge clk); #1;
        check("reset_held", 8'h00, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n;
            en    = vecs[i].en;
            req   = vecs[i].req;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_vld, vecs[i].exp_idx);
        end

        // Reset mid-grant between edges; grant must clear before the next edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_mid_grant", 8'h00, 0, 0);
        #1;
        rst_n = 1'b1;
        req   = 8'h21;
        @(posedge clk); #1;
        check("after_mid_reset", 8'h01, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- 8-requester round-robin arbiter with a registered one-hot grant vector.
- Sits directly upstream of the 8-to-3 encoder: gnt drives the encoder's d input, so the encoder only ever sees a legal one-hot code or all-zero.
- gnt_valid qualifies the encoded index downstream, because all-zero and bit-0 both encode to 000.
- Bounds grant tenure so that no requester can starve the others.

Parameters:
- N, 8, number of requesters; fixed at 8 to match the 8-to-3 encoder.
- MAX_HOLD, 4, maximum consecutive cycles one grant may be held while other requests are pending; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbitration enable; low forces release and blocks new grants.
- req  input  N  request vector; bit i high means requester i wants the resource.
- gnt  output  N  registered grant; always one-hot or all-zero, never multi-hot.
- gnt_valid  output  1  high exactly when gnt is non-zero.
- gnt_idx  output  3  binary index of the granted bit (registered alongside gnt); 0 when gnt_valid is low.

Behaviour:
- Reset (rst_n low, asynchronous):
  - gnt=0, gnt_valid=0, gnt_idx=0.
  - Internal: state=IDLE, ptr=0, hold_cnt=0.
  - Deassertion is sampled on the next rising edge.
- Arbitration function: starting at ptr, scan upward modulo 8; the first set req bit wins. ptr is the highest-priority position.
- Latency: 1 cycle. A req sampled at edge k produces gnt at edge k; gnt is visible in the cycle after the request is presented.
- State IDLE:
  - If en=1 and req!=0: grant the arbitration winner, hold_cnt=1, go to GRANT.
  - Otherwise gnt stays 0.
- State GRANT, granted index g, evaluated each edge in priority order:
  1. en=0: gnt=0, ptr=(g+1) mod 8, hold_cnt=0, go to IDLE.
  2. req[g]=0 (release): ptr=(g+1) mod 8; re-arbitrate in the same edge with the new ptr. If a winner exists, grant it with hold_cnt=1 and stay in GRANT (no bubble). Otherwise gnt=0 and go to IDLE.
  3. hold_cnt==MAX_HOLD and (req with bit g masked)!=0: forced rotation. ptr=(g+1) mod 8; grant the winner among the masked requests; hold_cnt=1.
  4. hold_cnt==MAX_HOLD and no other requests: keep g; hold_cnt saturates at MAX_HOLD.
  5. Otherwise keep g; hold_cnt+=1.
- Wrap-around: g=7 advances ptr to 0.
- Simultaneous release and new request at the same index: the released bit is treated as deasserted for that edge. Re-arbitration uses the current req, so a bit that re-asserts is eligible only behind the rotated ptr.
- gnt changes only on clock edges (except asynchronous reset). One-hot/zero is guaranteed in every cycle.
- Reset mid-grant: outputs clear immediately and pointer fairness history is lost (ptr=0).
- gnt_idx and gnt_valid are derived from the same register update as gnt. There is no cycle skew between them.

Test Plan:
- Reset: hold rst_n=0 with req=8'hFF, en=1 -> gnt=00000000, gnt_valid=0, gnt_idx=0. Release reset; after the next edge -> gnt=00000001, gnt_idx=0.
- Single request: req=00010000 -> after 1 edge gnt=00010000, gnt_idx=4, gnt_valid=1. Drop req -> next edge gnt=0, gnt_valid=0.
- Rotation: req=00100100 held, MAX_HOLD=4, ptr=0 -> gnt=00000100 for 4 cycles, then 00100000 for 4 cycles, then 00000100 again. gnt is never multi-hot.
- Wrap and release: grant on bit 7 (req=10000001, ptr=7). Drop req[7] -> next edge gnt=00000001 with no zero cycle between.
- Enable drop: while gnt=01000000, set en=0 -> next edge gnt=0, gnt_valid=0. Set en=1 with req=01000010 -> gnt=00000010 (ptr advanced to 7, wraps to bit 1).
- Async reset mid-grant: assert rst_n low between edges while gnt=00100000 -> gnt clears before the next edge. After release, req=00100001 -> gnt=00000001.
